// File: rtl/sram_4_port_arbiter_if.sv
// sram_4_port_arbiter_if
//   Requester-side handshake bundle for sram_4_port_arbiter. Each vector packs
//   four requesters; requester i owns bit i, address byte [8i+7:8i] and
//   data halfword [16i+15:16i].
//   master : requester side (drives requests, receives grants/responses)
//   slave  : arbiter side
interface sram_4_port_arbiter_if;
  logic [3:0]  Req_Valid_In;
  logic [3:0]  Req_Write_In;
  logic [31:0] Req_Address_In;
  logic [63:0] Req_Data_In;
  logic [3:0]  Req_Ready_Out;
  logic [3:0]  Rsp_Valid_Out;
  logic [63:0] Rsp_Data_Out;

  modport master (
    output Req_Valid_In, Req_Write_In, Req_Address_In, Req_Data_In,
    input  Req_Ready_Out, Rsp_Valid_Out, Rsp_Data_Out
  );

  modport slave (
    input  Req_Valid_In, Req_Write_In, Req_Address_In, Req_Data_In,
    output Req_Ready_Out, Rsp_Valid_Out, Rsp_Data_Out
  );
endinterface

// File: rtl/sram_4_port_arbiter.sv
// sram_4_port_arbiter
//   Round-robin arbiter/sequencer for a 16-bit x 256-word SRAM with two write
//   ports (A, B) and two read ports (C, D); the SRAM acts on the falling edge.
//   Each rising edge grants up to two writes and two reads, registers the SRAM
//   port signals, and one cycle later returns captured read data to the owner.
//   Ports:
//     Clk_In, Reset_In          clock (rising edge), async active-high reset
//     req_if (slave)            requester valid/write/address/data, ready,
//                               response valid pulse and held response data
//     Port_W_A_* / Port_W_B_*   registered SRAM write port signals
//     Port_R_C_* / Port_R_D_*   registered SRAM read address/enable, read data in
//   Optional feature: define SRAM_ARB_WRITE_FORWARD_EN to return same-cycle write
//   data to a read of the same address (port A takes precedence over B).
module sram_4_port_arbiter (
  input  logic                        Clk_In,
  input  logic                        Reset_In,
  sram_4_port_arbiter_if.slave        req_if,
  output logic [15:0]                 Port_W_A_Data_Out,
  output logic [7:0]                  Port_W_A_Address_Out,
  output logic                        Port_W_A_Write_Enable_Out,
  output logic [15:0]                 Port_W_B_Data_Out,
  output logic [7:0]                  Port_W_B_Address_Out,
  output logic                        Port_W_B_Write_Enable_Out,
  output logic [7:0]                  Port_R_C_Address_Out,
  output logic                        Port_R_C_Read_Enable_Out,
  input  logic [15:0]                 Port_R_C_Data_In,
  output logic [7:0]                  Port_R_D_Address_Out,
  output logic                        Port_R_D_Read_Enable_Out,
  input  logic [15:0]                 Port_R_D_Data_In
);

  logic [3:0][7:0]  req_addr;
  logic [3:0][15:0] req_data;
  logic [3:0][15:0] rsp_data;
  logic [3:0]       rsp_valid;
  logic [1:0]       ptr;

  // Grant decisions for the current cycle
  logic       a_valid, b_valid, c_valid, d_valid;
  logic [1:0] a_id, b_id, c_id, d_id;
  logic [7:0] a_addr;
  logic [1:0] last_pos;
  logic [3:0] ready;
  logic [1:0] r;

  // Read owners registered with the grant
  logic       own_c_valid, own_d_valid;
  logic [1:0] own_c, own_d;
  logic [15:0] c_rdata, d_rdata;

  assign req_addr = req_if.Req_Address_In;
  assign req_data = req_if.Req_Data_In;
  assign req_if.Rsp_Data_Out  = rsp_data;
  assign req_if.Rsp_Valid_Out = rsp_valid;
  // Grants are suppressed while reset is held so no request looks accepted.
  assign req_if.Req_Ready_Out = ready & {4{~Reset_In}};

  // Single priority scan from the pointer. A second writer whose address
  // matches port A's is skipped so a later writer can take port B instead.
  always_comb begin
    a_valid  = 1'b0;
    b_valid  = 1'b0;
    c_valid  = 1'b0;
    d_valid  = 1'b0;
    a_id     = '0;
    b_id     = '0;
    c_id     = '0;
    d_id     = '0;
    a_addr   = '0;
    last_pos = '0;
    ready    = '0;
    r        = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      r = ptr + 2'(k);
      if (req_if.Req_Valid_In[r]) begin
        if (req_if.Req_Write_In[r]) begin
          if (!a_valid) begin
            a_valid  = 1'b1;
            a_id     = r;
            a_addr   = req_addr[r];
            ready[r] = 1'b1;
            last_pos = 2'(k);
          end else if (!b_valid && (req_addr[r] != a_addr)) begin
            b_valid  = 1'b1;
            b_id     = r;
            ready[r] = 1'b1;
            last_pos = 2'(k);
          end
        end else begin
          if (!c_valid) begin
            c_valid  = 1'b1;
            c_id     = r;
            ready[r] = 1'b1;
            last_pos = 2'(k);
          end else if (!d_valid) begin
            d_valid  = 1'b1;
            d_id     = r;
            ready[r] = 1'b1;
            last_pos = 2'(k);
          end
        end
      end
    end
  end

  // Read data selection; the port registers still hold the writes granted
  // alongside these reads, so they double as the forwarding source.
  always_comb begin
`ifdef SRAM_ARB_WRITE_FORWARD_EN
    if (Port_W_A_Write_Enable_Out && (Port_W_A_Address_Out == Port_R_C_Address_Out))
      c_rdata = Port_W_A_Data_Out;
    else if (Port_W_B_Write_Enable_Out && (Port_W_B_Address_Out == Port_R_C_Address_Out))
      c_rdata = Port_W_B_Data_Out;
    else
      c_rdata = Port_R_C_Data_In;
    if (Port_W_A_Write_Enable_Out && (Port_W_A_Address_Out == Port_R_D_Address_Out))
      d_rdata = Port_W_A_Data_Out;
    else if (Port_W_B_Write_Enable_Out && (Port_W_B_Address_Out == Port_R_D_Address_Out))
      d_rdata = Port_W_B_Data_Out;
    else
      d_rdata = Port_R_D_Data_In;
`else
    c_rdata = Port_R_C_Data_In;
    d_rdata = Port_R_D_Data_In;
`endif
  end

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      ptr                       <= '0;
      Port_W_A_Data_Out         <= '0;
      Port_W_A_Address_Out      <= '0;
      Port_W_A_Write_Enable_Out <= 1'b0;
      Port_W_B_Data_Out         <= '0;
      Port_W_B_Address_Out      <= '0;
      Port_W_B_Write_Enable_Out <= 1'b0;
      Port_R_C_Address_Out      <= '0;
      Port_R_C_Read_Enable_Out  <= 1'b0;
      Port_R_D_Address_Out      <= '0;
      Port_R_D_Read_Enable_Out  <= 1'b0;
      own_c_valid               <= 1'b0;
      own_d_valid               <= 1'b0;
      own_c                     <= '0;
      own_d                     <= '0;
      rsp_valid                 <= '0;
      rsp_data                  <= '0;
    end else begin
      // Next priority starts just past the last requester granted in scan order.
      if (|ready)
        ptr <= ptr + last_pos + 2'd1;

      Port_W_A_Write_Enable_Out <= a_valid;
      if (a_valid) begin
        Port_W_A_Address_Out <= a_addr;
        Port_W_A_Data_Out    <= req_data[a_id];
      end
      Port_W_B_Write_Enable_Out <= b_valid;
      if (b_valid) begin
        Port_W_B_Address_Out <= req_addr[b_id];
        Port_W_B_Data_Out    <= req_data[b_id];
      end
      Port_R_C_Read_Enable_Out <= c_valid;
      if (c_valid)
        Port_R_C_Address_Out <= req_addr[c_id];
      Port_R_D_Read_Enable_Out <= d_valid;
      if (d_valid)
        Port_R_D_Address_Out <= req_addr[d_id];

      own_c_valid <= c_valid;
      own_c       <= c_id;
      own_d_valid <= d_valid;
      own_d       <= d_id;

      // C and D owners are always distinct requesters, so the bits never clash.
      rsp_valid <= '0;
      if (own_c_valid) begin
        rsp_data[own_c]  <= c_rdata;
        rsp_valid[own_c] <= 1'b1;
      end
      if (own_d_valid) begin
        rsp_data[own_d]  <= d_rdata;
        rsp_valid[own_d] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_4_port_arbiter.sv
module tb_sram_4_port_arbiter;
  logic        clk;
  logic        rst;
  logic [15:0] wa_data, wb_data, rc_data, rd_data;
  logic [7:0]  wa_addr, wb_addr, rc_addr, rd_addr;
  logic        wa_we, wb_we, rc_re, rd_re;
  logic [15:0] mem [256];
  int n_checks;
  int n_fail;

  sram_4_port_arbiter_if bus ();

  sram_4_port_arbiter dut (
    .Clk_In                    (clk),
    .Reset_In                  (rst),
    .req_if                    (bus.slave),
    .Port_W_A_Data_Out         (wa_data),
    .Port_W_A_Address_Out      (wa_addr),
    .Port_W_A_Write_Enable_Out (wa_we),
    .Port_W_B_Data_Out         (wb_data),
    .Port_W_B_Address_Out      (wb_addr),
    .Port_W_B_Write_Enable_Out (wb_we),
    .Port_R_C_Address_Out      (rc_addr),
    .Port_R_C_Read_Enable_Out  (rc_re),
    .Port_R_C_Data_In          (rc_data),
    .Port_R_D_Address_Out      (rd_addr),
    .Port_R_D_Read_Enable_Out  (rd_re),
    .Port_R_D_Data_In          (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Falling-edge SRAM: reads see the contents from before this edge's writes.
  always @(negedge clk) begin
    if (rc_re) rc_data <= mem[rc_addr];
    if (rd_re) rd_data <= mem[rd_addr];
    if (wa_we) mem[wa_addr] <= wa_data;
    if (wb_we) mem[wb_addr] <= wb_data;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [7:0] a, input logic [15:0] d);
    bus.Req_Valid_In[i]          = 1'b1;
    bus.Req_Write_In[i]          = wr;
    bus.Req_Address_In[8*i +: 8] = a;
    bus.Req_Data_In[16*i +: 16]  = d;
  endtask

  task automatic drop(input int i);
    bus.Req_Valid_In[i] = 1'b0;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rc_data = '0;
    rd_data = '0;
    bus.Req_Valid_In   = '0;
    bus.Req_Write_In   = '0;
    bus.Req_Address_In = '0;
    bus.Req_Data_In    = '0;
    rst = 1'b1;
    #12;
    chk("reset_rsp_valid", {60'd0, bus.Rsp_Valid_Out}, 64'h0);
    chk("reset_rsp_data", bus.Rsp_Data_Out, 64'h0);
    chk("reset_wa", {39'd0, wa_we, wa_addr, wa_data}, 64'h0);
    chk("reset_enables", {60'd0, wb_we, rc_re, rd_re, 1'b0}, 64'h0);
    rst = 1'b0;
    tick();

    // Requester 2 writes 0xBEEF to 0x10, then reads it back
    set_req(2, 1'b1, 8'h10, 16'hBEEF);
    settle();
    chk("wr_ready", {60'd0, bus.Req_Ready_Out}, 64'h4);
    tick();
    chk("wr_port_a", {39'd0, wa_we, wa_addr, wa_data}, {39'd0, 1'b1, 8'h10, 16'hBEEF});
    chk("wr_port_b_en", {63'd0, wb_we}, 64'h0);
    set_req(2, 1'b0, 8'h10, 16'h0);
    settle();
    chk("rd_ready", {60'd0, bus.Req_Ready_Out}, 64'h4);
    tick();
    chk("rd_port_c", {55'd0, rc_re, rc_addr}, {55'd0, 1'b1, 8'h10});
    chk("rd_no_rsp_yet", {60'd0, bus.Rsp_Valid_Out}, 64'h0);
    drop(2);
    tick();
    chk("rd_rsp_valid", {60'd0, bus.Rsp_Valid_Out}, 64'h4);
    chk("rd_rsp_data", bus.Rsp_Data_Out, 64'h0000_BEEF_0000_0000);
    tick();
    chk("rd_rsp_pulse_end", {60'd0, bus.Rsp_Valid_Out}, 64'h0);
    chk("rd_rsp_hold", bus.Rsp_Data_Out, 64'h0000_BEEF_0000_0000);

    // Two reads in flight (pointer now 3), then reset mid-cycle
    set_req(0, 1'b0, 8'h10, 16'h0);
    set_req(1, 1'b0, 8'h20, 16'h0);
    settle();
    chk("flight_ready", {60'd0, bus.Req_Ready_Out}, 64'h3);
    tick();
    drop(0);
    drop(1);
    #3;
    rst = 1'b1;
    #2;
    chk("midrst_rsp_data", bus.Rsp_Data_Out, 64'h0);
    chk("midrst_ports", {29'd0, wa_we, wb_we, rc_re, rd_re, wa_addr, rc_addr, rd_addr, wa_data},
        64'h0);
    #1;
    rst = 1'b0;
    tick();
    chk("midrst_no_pulse", {60'd0, bus.Rsp_Valid_Out}, 64'h0);
    tick();
    chk("midrst_no_pulse2", {60'd0, bus.Rsp_Valid_Out}, 64'h0);

    // Four writers, pointer 0
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'h50 + 8'(i), 16'hA000 + 16'(i));
    settle();
    chk("w4_ready0", {60'd0, bus.Req_Ready_Out}, 64'h3);
    tick();
    chk("w4_a0", {39'd0, wa_we, wa_addr, wa_data}, {39'd0, 1'b1, 8'h50, 16'hA000});
    chk("w4_b0", {39'd0, wb_we, wb_addr, wb_data}, {39'd0, 1'b1, 8'h51, 16'hA001});
    drop(0);
    drop(1);
    settle();
    chk("w4_ready1", {60'd0, bus.Req_Ready_Out}, 64'hC);
    tick();
    chk("w4_a1", {39'd0, wa_we, wa_addr, wa_data}, {39'd0, 1'b1, 8'h52, 16'hA002});
    chk("w4_b1", {39'd0, wb_we, wb_addr, wb_data}, {39'd0, 1'b1, 8'h53, 16'hA003});
    drop(2);
    drop(3);

    // Write collision, pointer 0
    set_req(0, 1'b1, 8'h20, 16'h1000);
    set_req(1, 1'b1, 8'h20, 16'h2000);
    set_req(3, 1'b1, 8'h30, 16'h3000);
    settle();
    chk("coll_ready", {60'd0, bus.Req_Ready_Out}, 64'h9);
    tick();
    chk("coll_a", {39'd0, wa_we, wa_addr, wa_data}, {39'd0, 1'b1, 8'h20, 16'h1000});
    chk("coll_b", {39'd0, wb_we, wb_addr, wb_data}, {39'd0, 1'b1, 8'h30, 16'h3000});
    drop(0);
    drop(3);
    settle();
    chk("coll_ready2", {60'd0, bus.Req_Ready_Out}, 64'h2);
    tick();
    chk("coll_a2", {39'd0, wa_we, wa_addr, wa_data}, {39'd0, 1'b1, 8'h20, 16'h2000});
    chk("coll_b2_en", {63'd0, wb_we}, 64'h0);
    drop(1);

    // Four readers, pointer 2
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'h50 + 8'(i), 16'h0);
    settle();
    chk("r4_ready", {60'd0, bus.Req_Ready_Out}, 64'hC);
    tick();
    chk("r4_ports", {46'd0, rc_re, rc_addr, rd_re, rd_addr}, {46'd0, 1'b1, 8'h52, 1'b1, 8'h53});
    // Remaining readers plus two writers, pointer 0
    set_req(2, 1'b1, 8'h60, 16'h6002);
    set_req(3, 1'b1, 8'h61, 16'h6003);
    settle();
    chk("mix_ready", {60'd0, bus.Req_Ready_Out}, 64'hF);
    tick();
    chk("mix_rsp_valid", {60'd0, bus.Rsp_Valid_Out}, 64'hC);
    chk("mix_rsp_data", bus.Rsp_Data_Out, 64'hA003_A002_0000_0000);
    chk("mix_writes", {30'd0, wa_we, wa_addr, wb_we, wb_addr, wa_data},
        {30'd0, 1'b1, 8'h60, 1'b1, 8'h61, 16'h6002});
    for (int i = 0; i < 4; i++) drop(i);
    tick();
    chk("mix_rsp_valid2", {60'd0, bus.Rsp_Valid_Out}, 64'h3);
    chk("mix_rsp_data2", bus.Rsp_Data_Out, 64'hA003_A002_A001_A000);

    // Same-cycle read/write to 0x40; pointer 0
    set_req(0, 1'b1, 8'h40, 16'h1111);
    settle();
    chk("fw_pre_ready", {60'd0, bus.Req_Ready_Out}, 64'h1);
    tick();
    drop(0);
    set_req(1, 1'b1, 8'h40, 16'h2222);
    set_req(2, 1'b0, 8'h40, 16'h0);
    settle();
    chk("fw_ready", {60'd0, bus.Req_Ready_Out}, 64'h6);
    tick();
    drop(1);
    drop(2);
    tick();
    chk("fw_rsp_valid", {60'd0, bus.Rsp_Valid_Out}, 64'h4);
`ifdef SRAM_ARB_WRITE_FORWARD_EN
    chk("fw_rsp_data", bus.Rsp_Data_Out, 64'hA003_2222_A001_A000);
`else
    chk("fw_rsp_data", bus.Rsp_Data_Out, 64'hA003_1111_A001_A000);
`endif
    // Pointer is 3: requester 3 reads 0x40 back
    set_req(3, 1'b0, 8'h40, 16'h0);
    settle();
    chk("fw_post_ready", {60'd0, bus.Req_Ready_Out}, 64'h8);
    tick();
    drop(3);
    tick();
    chk("fw_post_valid", {60'd0, bus.Rsp_Valid_Out}, 64'h8);
    chk("fw_post_data", {48'd0, bus.Rsp_Data_Out[63:48]}, 64'h2222);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_4_port_arbiter.md
# sram_4_port_arbiter

Four-requester round-robin arbiter and sequencer in front of the 16-bit, 256-word 4-port SRAM (two write ports A/B, two read ports C/D, SRAM acting on the falling clock edge). Each cycle it grants up to two writes and two reads from four independent requesters. It drives the SRAM port signals from registers and routes captured read data back to the owning requester. It also prevents same-address write collisions on ports A and B.

## Interface
- No parameters; requester count 4, data width 16, address width 8, all fixed.
- Clk_In  input  1  clock; this block acts on the rising edge.
- Reset_In  input  1  asynchronous, active-high reset.
- Req_Valid_In  input  4  per-requester request valid, bit i = requester i.
- Req_Write_In  input  4  1 = write, 0 = read.
- Req_Address_In  input  32  requester i address at [8i+7:8i].
- Req_Data_In  input  64  requester i write data at [16i+15:16i].
- Req_Ready_Out  output  4  combinational grant; request accepted at a rising edge when Valid and Ready are both 1.
- Rsp_Valid_Out  output  4  one-cycle pulse; read data is valid for requester i.
- Rsp_Data_Out  output  64  requester i read data at [16i+15:16i]; holds its value until the next response.
- Port_W_A_Data_Out / Port_W_A_Address_Out / Port_W_A_Write_Enable_Out  output  16/8/1  to SRAM write port A.
- Port_W_B_Data_Out / Port_W_B_Address_Out / Port_W_B_Write_Enable_Out  output  16/8/1  to SRAM write port B.
- Port_R_C_Address_Out / Port_R_C_Read_Enable_Out  output  8/1  to SRAM read port C.
- Port_R_C_Data_In  input  16  from SRAM read port C.
- Port_R_D_Address_Out / Port_R_D_Read_Enable_Out  output  8/1  to SRAM read port D.
- Port_R_D_Data_In  input  16  from SRAM read port D.

## Operation
- 2-bit round-robin pointer P. Priority order is P, P+1, P+2, P+3 (mod 4).
- **Write grant.** Scan valid writers in priority order. The first goes to port A, the second to port B. If the second's address equals the first's, it is not granted that cycle; the next eligible writer in order takes B instead.
- **Read grant.** Scan valid readers in priority order. The first goes to port C, the second to port D. Reads to the same address are both granted.
- Req_Ready_Out[i] = 1 only when requester i is granted a port. Non-granted requesters must hold their request stable.
- **Pointer update.** On any grant, P becomes (highest-index-in-priority-order granted requester) + 1 mod 4. P is unchanged when no grant is made.
- **Port registers.** On acceptance, the granted port's address, data and enable registers load. Ungranted enables load 0, and their address/data registers hold.
- **Read return.** Owner IDs for ports C and D (2 bits each plus a valid bit) are registered with the grant. On the next rising edge, Port_R_x_Data_In is captured into the owner's Rsp_Data_Out and that owner's Rsp_Valid_Out pulses.
- **Read/write same address, same cycle.** The read returns the pre-write contents (SRAM non-blocking semantics). See Configuration for the alternative.
- **Reset values.** Pointer 0; all enables 0; all port addresses/data 0; Rsp_Valid_Out 0; Rsp_Data_Out 0; owner-valid bits 0. Reset during an in-flight read drops the response; no Rsp_Valid pulse follows.

## Timing
- **Edge k.** Request accepted; port registers drive the SRAM from edge k to edge k+1.
- **Falling edge between k and k+1.** SRAM performs the access.
- **Edge k+1.** Read data is captured; Rsp_Valid_Out is high for exactly one cycle. Read latency is 1 cycle after acceptance. A write is complete before edge k+1.
- **Throughput.** Up to 2 reads plus 2 writes per cycle. A requester may issue back-to-back requests every cycle.
- Port_R_x_Data_In is sampled only when that port's owner-valid bit is set, so a Z value from an idle port is never captured.

## Configuration
- **SRAM_ARB_WRITE_FORWARD_EN defined.** When a read granted at edge k matches the address of a write granted at edge k, the response returns the write data instead of the SRAM data. Port A has precedence over port B, although the write conflict rule makes A and B addresses always differ.
- **Undefined.** The response returns the pre-write value.

## Test plan
- **Reset.** Assert Reset_In mid-cycle with reads in flight → all outputs 0 immediately and no Rsp_Valid pulse afterwards; P = 0.
- **Single write then read.** Requester 2 writes 0xBEEF to 0x10; next cycle it reads 0x10 → granted on port A then port C; Rsp_Data_Out[47:32] = 0xBEEF with Rsp_Valid_Out = 4'b0100, one cycle after the read is accepted.
- **Four writers, P = 0, distinct addresses.** Requesters 0 and 1 granted on A and B; P becomes 2; next cycle requesters 2 and 3 are granted.
- **Write collision.** Requesters 0 and 1 both write 0x20, requester 3 writes 0x30 → grants go to 0 (port A) and 3 (port B); requester 1 is granted the next cycle.
- **Four readers plus two writers in the same cycle.** Expect 2 read grants, 2 write grants and 2 responses; Ready is 0 for the remaining readers.
- **Read and write to 0x40 in the same cycle, old value 0x1111, new value 0x2222.** Response is 0x1111 without SRAM_ARB_WRITE_FORWARD_EN and 0x2222 with it.
